// File: rtl/boid_pixel_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// boid_pixel_writer : erases a boid's old SIZExSIZE square, then draws its new
//                     square into the framebuffer, one clipped pixel per cycle.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module boid_pixel_writer #(
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          SIZE      = 2,
  parameter int          FRAC_BITS = 16,
  parameter logic [7:0]  BG_COLOR  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] px_in,
  input  logic [31:0] py_in,
  input  logic [7:0]  color_in,
  input  logic        skip_erase,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LAST = 2'(SIZE - 1);

  state_t             state_q, state_d;
  logic [1:0]         i_q, i_d, j_q, j_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic [7:0]         color_q, color_d;
  logic               fb_we_q, fb_we_d;
  logic [18:0]        fb_addr_q, fb_addr_d;
  logic [7:0]         fb_wdata_q, fb_wdata_d;

  logic               gen_en, gen_erase, last_px;
  logic signed [31:0] gen_bx, gen_by;

  // Returns {write_enable, address}; write_enable is low for off-screen pixels.
  function automatic logic [19:0] pixel(input logic signed [31:0] bx,
                                        input logic signed [31:0] by,
                                        input logic [1:0]         i,
                                        input logic [1:0]         j);
    logic signed [31:0] col, row;
    col = bx + $signed({30'd0, i});
    row = by + $signed({30'd0, j});
    if (col < 0 || col >= SCREEN_W || row < 0 || row >= SCREEN_H)
      pixel = 20'd0;
    else
      pixel = {1'b1, 19'(row * SCREEN_W + col)};
  endfunction

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    x_d        = x_q;
    y_d        = y_q;
    px_d       = px_q;
    py_d       = py_q;
    color_d    = color_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = 19'd0;
    fb_wdata_d = 8'd0;
    gen_en     = 1'b0;
    gen_erase  = 1'b0;
    gen_bx     = x_q;
    gen_by     = y_q;
    last_px    = (i_q == LAST) && (j_q == LAST);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = $signed(x_in) >>> FRAC_BITS;
          y_d     = $signed(y_in) >>> FRAC_BITS;
          px_d    = $signed(px_in) >>> FRAC_BITS;
          py_d    = $signed(py_in) >>> FRAC_BITS;
          color_d = color_in;
          i_d     = 2'd0;
          j_d     = 2'd0;
          state_d = skip_erase ? DRAW : ERASE;
          gen_en    = 1'b1;
          gen_erase = !skip_erase;
          gen_bx    = skip_erase ? x_d : px_d;
          gen_by    = skip_erase ? y_d : py_d;
        end
      end
      ERASE: begin
        gen_en = 1'b1;
        if (last_px) begin
          i_d     = 2'd0;
          j_d     = 2'd0;
          state_d = DRAW;
        end else begin
          gen_erase = 1'b1;
          gen_bx    = px_q;
          gen_by    = py_q;
          i_d       = (i_q == LAST) ? 2'd0 : i_q + 2'd1;
          j_d       = (i_q == LAST) ? j_q + 2'd1 : j_q;
        end
      end
      DRAW: begin
        if (last_px) begin
          state_d = DONE;
        end else begin
          gen_en = 1'b1;
          i_d    = (i_q == LAST) ? 2'd0 : i_q + 2'd1;
          j_d    = (i_q == LAST) ? j_q + 2'd1 : j_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // i_d/j_d name the pixel that will be on the write port next cycle.
    if (gen_en) begin
      {fb_we_d, fb_addr_d} = pixel(gen_bx, gen_by, i_d, j_d);
      fb_wdata_d           = gen_erase ? BG_COLOR : color_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= 2'd0;
      j_q        <= 2'd0;
      x_q        <= '0;
      y_q        <= '0;
      px_q       <= '0;
      py_q       <= '0;
      color_q    <= 8'd0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= 19'd0;
      fb_wdata_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      x_q        <= x_d;
      y_q        <= y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      color_q    <= color_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign done     = (state_q == DONE);
  assign in_ready = (state_q == IDLE) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_boid_pixel_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_boid_pixel_writer : directed scoreboard bench for boid_pixel_writer.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_boid_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in, y_in, px_in, py_in;
  logic [7:0]  color_in;
  logic        skip_erase;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        done;

  typedef struct packed {
    logic        we;
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  boid_pixel_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .px_in(px_in), .py_in(py_in),
    .color_in(color_in), .skip_erase(skip_erase),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
      $error("check %s wrong", tag);
    end
  endtask

  task automatic push(input logic we, input logic [18:0] addr, input logic [7:0] data);
    exp_q.push_back({we, addr, data});
  endtask

  task automatic chk_pixel(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_we"}, {31'd0, fb_we}, {31'd0, e.we});
      if (e.we) begin
        chk({tag, "_addr"}, {13'd0, fb_addr}, {13'd0, e.addr});
        chk({tag, "_data"}, {24'd0, fb_wdata}, {24'd0, e.data});
      end
    end
  endtask

  task automatic drive(input logic [31:0] x, y, px, py, input logic [7:0] c, input logic s);
    x_in = x; y_in = y; px_in = px; py_in = py; color_in = c; skip_erase = s;
  endtask

  // Accept in cycle 0, check npix write cycles, then the done cycle.
  task automatic do_req(input string tag, input logic [31:0] x, y, px, py,
                        input logic [7:0] c, input logic s, input int npix);
    @(posedge clk); #1;
    drive(x, y, px, py, c, s);
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_c0"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom, 8'($urandom), 1'($urandom));
    for (int k = 0; k < npix; k++) begin
      @(negedge clk);
      chk_pixel(tag);
      chk({tag, "_busy"}, {30'd0, in_ready, done}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {30'd0, done, in_ready}, 32'd2);
    chk({tag, "_done_we"}, {31'd0, fb_we}, 32'd0);
  endtask

  task automatic push_basic();
    push(1, 19'd12809, 8'h00); push(1, 19'd12810, 8'h00);
    push(1, 19'd13449, 8'h00); push(1, 19'd13450, 8'h00);
    push(1, 19'd12810, 8'hE0); push(1, 19'd12811, 8'hE0);
    push(1, 19'd13450, 8'hE0); push(1, 19'd13451, 8'hE0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outs", {fb_we, fb_addr, fb_wdata, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Basic erase + draw
    push_basic();
    do_req("basic", 32'h000A_8000, 32'h0014_0000, 32'h0009_0000, 32'h0014_0000, 8'hE0, 1'b0, 8);

    // Bottom-right corner clip
    push(1, 19'd307199, 8'h1C); push(0, 19'd0, 8'h00);
    push(0, 19'd0, 8'h00);      push(0, 19'd0, 8'h00);
    do_req("edge", 32'h027F_0000, 32'h01DF_0000, 32'h0, 32'h0, 8'h1C, 1'b1, 4);

    // Overlapping erase and draw
    push(1, 19'd3205, 8'h00); push(1, 19'd3206, 8'h00);
    push(1, 19'd3845, 8'h00); push(1, 19'd3846, 8'h00);
    push(1, 19'd3205, 8'h5A); push(1, 19'd3206, 8'h5A);
    push(1, 19'd3845, 8'h5A); push(1, 19'd3846, 8'h5A);
    do_req("overlap", 32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 8'h5A, 1'b0, 8);

    // Reset asserted in cycle 3 of a basic request
    push_basic();
    @(posedge clk); #1;
    drive(32'h000A_8000, 32'h0014_0000, 32'h0009_0000, 32'h0014_0000, 8'hE0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_c0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk_pixel("rstmid_c1");
    @(negedge clk); chk_pixel("rstmid_c2");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_pixel("rstmid_c3");
    chk("rstmid_ready_c3", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ready_c4", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk("rstmid_quiet", {30'd0, fb_we, done}, 32'd0);
      @(negedge clk);
    end
    exp_q.delete();
    push_basic();
    do_req("after_rst", 32'h000A_8000, 32'h0014_0000, 32'h0009_0000, 32'h0014_0000, 8'hE0, 1'b0, 8);

    // Back-to-back with in_valid held high; second request is the negative clip
    push_basic();
    push(0, 19'd0, 8'h00);   push(1, 19'd0, 8'h33);
    push(0, 19'd0, 8'h00);   push(1, 19'd640, 8'h33);
    @(posedge clk); #1;
    drive(32'h000A_8000, 32'h0014_0000, 32'h0009_0000, 32'h0014_0000, 8'hE0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready_c0", {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) drive(32'hFFFF_8000, 32'h0, 32'h0, 32'h0, 8'h33, 1'b1);
      chk("b2b_ready_busy", {31'd0, in_ready}, 32'd0);
      if (c <= 8) chk_pixel("b2b_a");
      else chk("b2b_a_done", {31'd0, done}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_ready_c10", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_pixel("b2b_neg");
    end
    @(negedge clk);
    chk("b2b_neg_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boid_pixel_writer.md
# boid_pixel_writer

Downstream of the boid accelerator: takes one boid's updated position and previous position (16.16 fixed point) and rasterises it into the VGA M10K framebuffer. It first erases a SIZE×SIZE square at the previous position with the background colour, then draws a SIZE×SIZE square at the new position in the boid colour. It writes one pixel per cycle through the framebuffer write port, clips pixels that fall off-screen, and signals completion so the controller can hand it the next boid.

## Interface
- SCREEN_W, 640, framebuffer width in pixels
- SCREEN_H, 480, framebuffer height in pixels
- SIZE, 2, sprite edge length in pixels (1..4)
- FRAC_BITS, 16, fractional bits of the position inputs
- BG_COLOR, 8'h00, erase colour
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request: position set is valid
- in_ready  out  1  block can accept a request
- x_in, y_in  in  32 each  new position, signed 16.16
- px_in, py_in  in  32 each  previous position, signed 16.16
- color_in  in  8  draw colour
- skip_erase  in  1  when 1, omit the erase phase (first frame)
- fb_we  out  1  framebuffer write enable
- fb_addr  out  19  framebuffer word address, row*SCREEN_W+col
- fb_wdata  out  8  pixel colour
- done  out  1  one-cycle pulse when the request has completed

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch all inputs.
  - Integer coordinates: x_in>>>FRAC_BITS and y_in>>>FRAC_BITS, arithmetic shift, so the value is floored. px_in and py_in are converted the same way.
  - Go to ERASE, or to DRAW if skip_erase=1.
- ERASE: SIZE² cycles. Visit pixel (px+i, py+j), row-major: j is the outer loop, i the inner, both 0..SIZE-1. Write data is BG_COLOR. Then go to DRAW.
- DRAW: SIZE² cycles, same order at (x+i, y+j). Write data is the latched color_in. Then go to DONE.
- DONE: done=1 for one cycle, in_ready=0. Then go to IDLE.
- Clipping:
  - A pixel is clipped if col<0, col≥SCREEN_W, row<0 or row≥SCREEN_H, evaluated on the signed integer coordinate.
  - A clipped pixel still consumes its cycle, with fb_we=0.
  - fb_addr and fb_wdata are don't-care whenever fb_we=0.
- Address: row*SCREEN_W+col, computed at least 20 bits wide, truncated to 19 bits only for unclipped pixels (max 307199).
- Overlapping erase and draw squares: the draw writes land later, so the boid colour wins.
- Inputs other than in_valid are ignored outside the accept cycle.
- reset=1:
  - State goes to IDLE.
  - fb_we=0, fb_addr=0, fb_wdata=0, done=0.
  - in_ready is forced to 0 while reset is high.
  - An in-flight request is abandoned: no further writes and no done pulse.

## Timing
- Accept in cycle 0.
- fb_we/fb_addr/fb_wdata are registered. Pixel k (0-based over the erase pixels, then the draw pixels) appears in cycle 1+k.
- With erase: writes in cycles 1..2·SIZE², done in cycle 2·SIZE²+1, in_ready=1 from cycle 2·SIZE²+2. With SIZE=2: writes 1–8, done 9, ready 10.
- Without erase: writes 1..SIZE², done SIZE²+1, ready SIZE²+2.
- Throughput with in_valid held high: one request every 2·SIZE²+2 cycles.
- Reset values: in_ready=0 during reset, 1 in the first cycle after deassertion. All other outputs are 0.

## Test plan
- Basic, SIZE=2. Inputs: x_in=0x000A_8000, y_in=0x0014_0000, px_in=0x0009_0000, py_in=0x0014_0000, color_in=0xE0, skip_erase=0.
  - Required: cycles 1–4 write 0x00 to 12809, 12810, 13449, 13450.
  - Cycles 5–8 write 0xE0 to 12810, 12811, 13450, 13451.
  - done in cycle 9, in_ready in cycle 10.
- Edge clip. Inputs: x_in=0x027F_0000 (639), y_in=0x01DF_0000 (479), skip_erase=1.
  - Required: cycle 1 writes to 307199.
  - Cycles 2–4 have fb_we=0.
  - done in cycle 5.
- Negative clip. Inputs: x_in=0xFFFF_8000 (floor −1), y_in=0, skip_erase=1.
  - Required: cycle 1 has fb_we=0.
  - Cycle 2 writes to 0, cycle 3 has fb_we=0, cycle 4 writes to 640.
- Reset mid-operation: assert reset in cycle 3 of a basic request.
  - Required: fb_we=0 from cycle 4 on, and no done pulse.
  - in_ready=1 the cycle after reset drops.
  - A new request afterwards completes normally.
- Back-to-back: in_valid held high with two requests.
  - Required: second accept in cycle 10.
  - Its first write in cycle 11.
  - in_ready=0 throughout cycles 1–9.
- Overlap: old and new position identical, (5,5).
  - Required: erase writes to 3205, 3206, 3845, 3846.
  - Draw writes with color_in to the same addresses immediately after.
